// File: rtl/top_udiv_pkg.sv
// Shared types and constants for the sequential 64/32 unsigned divider.
// Optional feature macro: TOP_UDIV_RADIX4_EN (two restoring steps per cycle).
package top_udiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned DefDividendWidth = 64;
  localparam int unsigned DefDivisorWidth  = 32;

`ifdef TOP_UDIV_RADIX4_EN
  localparam int unsigned StepsPerCycle = 2;
`else
  localparam int unsigned StepsPerCycle = 1;
`endif

  // Counter must hold the full step count, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DefCntWidth = cnt_width(DefDividendWidth);

endpackage

// File: rtl/top_udiv_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, emit the quotient bit.
module top_udiv_step
  import top_udiv_pkg::*;
#(
  parameter int unsigned DIVISOR_WIDTH = DefDivisorWidth
) (
  input  logic [DIVISOR_WIDTH:0]   prem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [DIVISOR_WIDTH:0]   prem_o,
  output logic                     qbit_o
);

  logic [DIVISOR_WIDTH:0] shifted;
  logic [DIVISOR_WIDTH:0] diff;

  // Restoring step; a set prem_i MSB means the shifted value already exceeds
  // any divisor, and the modular difference still fits since it is < divisor.
  always_comb begin
    shifted = {prem_i[DIVISOR_WIDTH-1:0], bit_i};
    diff    = shifted - {1'b0, divisor_i};
    qbit_o  = prem_i[DIVISOR_WIDTH] | (shifted >= {1'b0, divisor_i});
    prem_o  = qbit_o ? diff : shifted;
  end

endmodule

// File: rtl/top_udiv_64ns_32ns_seq.sv
// Sequential unsigned divider, 64-bit dividend / 32-bit divisor, restoring
// algorithm with valid/ready handshakes on both sides.
// Optional feature macro: TOP_UDIV_RADIX4_EN (two steps per cycle).
module top_udiv_64ns_32ns_seq
  import top_udiv_pkg::*;
#(
  parameter int unsigned ID             = 1,
  parameter int unsigned DIVIDEND_WIDTH = DefDividendWidth,
  parameter int unsigned DIVISOR_WIDTH  = DefDivisorWidth
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      div_by_zero
);

  localparam int unsigned Dw   = DIVIDEND_WIDTH;
  localparam int unsigned Vw   = DIVISOR_WIDTH;
  localparam int unsigned CntW = cnt_width(Dw);
  localparam logic [CntW-1:0] CntLoad = CntW'(Dw / StepsPerCycle);

  // ID is a tooling tag only.
  logic unused_id;
  assign unused_id = ^ID;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Dw-1:0]   dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [Vw-1:0]   dvs_q, dvs_d;
  logic [Vw:0]     prem_q, prem_d;
  logic            dbz_q, dbz_d;   // divisor was zero at accept
  logic [Dw-1:0]   quot_q, quot_d;
  logic [Vw-1:0]   rem_q, rem_d;
  logic            dbzo_q, dbzo_d;

  logic            accept;
  logic            cnt_last;
  logic [Vw:0]     prem_step;
  logic [Dw-1:0]   dvd_step;

  logic [Vw:0]     prem_s1;
  logic            qbit1;

  top_udiv_step #(
    .DIVISOR_WIDTH(Vw)
  ) u_step0 (
    .prem_i   (prem_q),
    .bit_i    (dvd_q[Dw-1]),
    .divisor_i(dvs_q),
    .prem_o   (prem_s1),
    .qbit_o   (qbit1)
  );

`ifdef TOP_UDIV_RADIX4_EN
  logic [Vw:0] prem_s2;
  logic        qbit2;

  top_udiv_step #(
    .DIVISOR_WIDTH(Vw)
  ) u_step1 (
    .prem_i   (prem_s1),
    .bit_i    (dvd_q[Dw-2]),
    .divisor_i(dvs_q),
    .prem_o   (prem_s2),
    .qbit_o   (qbit2)
  );

  assign prem_step = prem_s2;
  assign dvd_step  = {dvd_q[Dw-3:0], qbit1, qbit2};
`else
  assign prem_step = prem_s1;
  assign dvd_step  = {dvd_q[Dw-2:0], qbit1};
`endif

  assign accept   = in_valid && (state_q == StIdle);
  assign cnt_last = (cnt_q == CntW'(1));

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: if (cnt_last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbzo_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      dbz_q  <= dbz_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbzo_q <= dbzo_d;
    end
  end

  // Datapath next-state: load on accept, step while busy, publish on the last step.
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    dbz_d  = dbz_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbzo_d = dbzo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dvd_d  = din0;
          dvs_d  = din1;
          prem_d = '0;
          cnt_d  = CntLoad;
          dbz_d  = (din1 == '0);
        end
      end
      StBusy: begin
        dvd_d  = dvd_step;
        prem_d = prem_step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_last) begin
          quot_d = dbz_q ? '1 : dvd_step;
          // With a zero divisor every step keeps the shifted value, so the
          // partial remainder ends up as the low dividend bits.
          rem_d  = prem_step[Vw-1:0];
          dbzo_d = dbz_q;
        end
      end
      default: ;
    endcase
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_top_udiv_64ns_32ns_seq.sv
// Self-checking bench for top_udiv_64ns_32ns_seq: directed vectors, backpressure,
// mid-operation reset and a random stream checked against the division identity.
module tb_top_udiv_64ns_32ns_seq;

`ifdef TOP_UDIV_RADIX4_EN
  localparam int ExpLat = 33;
`else
  localparam int ExpLat = 65;
`endif
  localparam int NumRand = 600;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din0;
  logic [31:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
  } op_t;

  op_t pend[$];

  top_udiv_64ns_32ns_seq #(
    .ID(1),
    .DIVIDEND_WIDTH(64),
    .DIVISOR_WIDTH(32)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din0       (din0),
    .din1       (din1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Latency counts negedges after the accept edge, so the
  // first negedge after acceptance is cycle 1.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input int hold,
                        output logic [63:0] q, output logic [31:0] r, output logic z,
                        output int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge ap_clk);
      guard++;
    end
    if (!in_ready) check("start_timeout", 96'(in_ready), 96'd1);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    @(negedge ap_clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge ap_clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 96'(out_valid), 96'd1);
    q = quot;
    r = rem;
    z = div_by_zero;
    repeat (hold) @(negedge ap_clk);
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    logic        stable;
    logic [95:0] prod;
    int          pushed;
    int          popped;
    int          cyc;
    op_t         op;

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_in_ready", 96'(in_ready), 96'd1);
    check("rst_out_valid", 96'(out_valid), 96'd0);
    check("rst_quot", 96'(quot), 96'd0);
    check("rst_rem", 96'(rem), 96'd0);
    check("rst_dbz", 96'(div_by_zero), 96'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    run_op(64'd100, 32'd7, 0, q, r, z, lat);
    check("d100_lat", 96'(lat), 96'(ExpLat));
    check("d100_quot", 96'(q), 96'd14);
    check("d100_rem", 96'(r), 96'd2);
    check("d100_dbz", 96'(z), 96'd0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, q, r, z, lat);
    check("max_quot", 96'(q), 96'h0000_0001_0000_0001);
    check("max_rem", 96'(r), 96'd0);

    run_op(64'd5, 32'd9, 0, q, r, z, lat);
    check("small_quot", 96'(q), 96'd0);
    check("small_rem", 96'(r), 96'd5);

    run_op(64'd123456789, 32'd0, 0, q, r, z, lat);
    check("dbz_lat", 96'(lat), 96'(ExpLat));
    check("dbz_quot", 96'(q), 96'hFFFF_FFFF_FFFF_FFFF);
    check("dbz_rem", 96'(r), 96'h075B_CD15);
    check("dbz_flag", 96'(z), 96'd1);

    // Backpressure: hold the result for 10 cycles while offering new operands.
    in_valid = 1'b1;
    din0     = 64'd1000;
    din1     = 32'd10;
    @(negedge ap_clk);
    din0 = 64'd7;
    din1 = 32'd3;
    lat  = 1;
    while (!out_valid && lat < 200) begin
      @(negedge ap_clk);
      lat++;
    end
    check("bp_lat", 96'(lat), 96'(ExpLat));
    q      = quot;
    r      = rem;
    z      = div_by_zero;
    stable = 1'b1;
    repeat (10) begin
      @(negedge ap_clk);
      if (!out_valid || in_ready || quot !== q || rem !== r || div_by_zero !== z) stable = 1'b0;
    end
    check("bp_stable", 96'(stable), 96'd1);
    check("bp_quot", 96'(q), 96'd100);
    check("bp_rem", 96'(r), 96'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    check("bp_rel_in_ready", 96'(in_ready), 96'd1);
    check("bp_rel_out_valid", 96'(out_valid), 96'd0);

    // Reset 30 cycles into a busy operation.
    in_valid = 1'b1;
    din0     = 64'hDEAD_BEEF_1234_5678;
    din1     = 32'h1234;
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (29) @(negedge ap_clk);
    check("mid_busy", 96'(in_ready), 96'd0);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 96'(in_ready), 96'd1);
    check("mid_rst_out_valid", 96'(out_valid), 96'd0);
    check("mid_rst_quot", 96'(quot), 96'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    run_op(64'd42, 32'd5, 2, q, r, z, lat);
    check("post_rst_lat", 96'(lat), 96'(ExpLat));
    check("post_rst_quot", 96'(q), 96'd8);
    check("post_rst_rem", 96'(r), 96'd2);

    // Random stream with random valid/ready gaps; results checked in accept order.
    pushed = 0;
    popped = 0;
    cyc    = 0;
    while (popped < NumRand && cyc < 90000) begin
      @(negedge ap_clk);
      cyc++;
      in_valid = (pushed < NumRand) && ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        din0 = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) din0 = 64'($urandom_range(0, 100000));
        din1 = $urandom();
        if ($urandom_range(0, 3) == 0) din1 = 32'($urandom_range(1, 255));
        if (din1 == '0) din1 = 32'd1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (pend.size() == 0) begin
          check("rnd_spurious", 96'(out_valid), 96'd0);
        end else begin
          op   = pend.pop_front();
          prod = 96'(quot) * 96'(op.b) + 96'(rem);
          check("rnd_identity", prod, 96'(op.a));
          check("rnd_rem_lt", 96'(rem < op.b), 96'd1);
          check("rnd_quot", 96'(quot), 96'(op.a / 64'(op.b)));
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        op.a = din0;
        op.b = din1;
        pend.push_back(op);
        pushed++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (popped != NumRand) check("rnd_timeout", 96'(popped), 96'(NumRand));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
